// File: rtl/idex_pkg.sv
// Shared types for the ID/EX pipeline register: control bundle layout,
// the bubble constant and the occupancy state encoding.
package idex_pkg;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       branch_flip;
        logic       mem_read;
        logic       mem_write;
        logic       jump;
        logic       reg_write;
        logic       mem_to_reg;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_BUBBLE = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } idex_state_t;

endpackage

// File: rtl/idex_slot.sv
// One ID/EX payload register. Reset zeroes everything; clear zeroes only the
// control field so an emptied slot always presents a bubble.
module idex_slot
    import idex_pkg::*;
#(
    parameter int BODY_W = 80,
    parameter int CTRL_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [BODY_W-1:0] body,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [BODY_W-1:0] held_body,
    output logic [CTRL_W-1:0] held_ctrl
);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every slot samples pre-edge values of its neighbours.
        if (!reset) begin
            held_body <= '0;
            held_ctrl <= '0;
        end else if (clear) begin
            held_ctrl <= CTRL_W'(IDEX_BUBBLE);
        end else if (load) begin
            held_body <= body;
            held_ctrl <= ctrl;
        end
    end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush and bubble zeroing.
// Define IDEX_SKID_EN for a 2-entry build with registered in_ready.
module idex_pipe_reg
    import idex_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int CTRL_W  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_rd1,
    input  logic [DATA_W-1:0]  in_rd2,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_rd1,
    output logic [DATA_W-1:0]  out_rd2,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc4,
    output logic [CTRL_W-1:0]  out_ctrl
);

    localparam int BODY_W = 2 * DATA_W + INSTR_W + PC_W;

    idex_state_t        state_q, state_d;
    logic               accept, pop;
    logic               main_load, main_clear;
    logic [BODY_W-1:0]  in_body, main_body, main_body_d;
    logic [CTRL_W-1:0]  main_ctrl_d;

    assign in_body = {in_rd1, in_rd2, in_instr, in_pc4};
    assign {out_rd1, out_rd2, out_instr, out_pc4} = main_body;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef IDEX_SKID_EN
    logic               skid_load, skid_clear, main_from_skid;
    logic [BODY_W-1:0]  skid_body;
    logic [CTRL_W-1:0]  skid_ctrl;

    // Readiness comes from registered occupancy only; out_ready never reaches it.
    assign in_ready    = reset & ~flush & (state_q != TWO);
    assign main_body_d = main_from_skid ? skid_body : in_body;
    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;

    idex_slot #(.BODY_W(BODY_W), .CTRL_W(CTRL_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .body      (in_body),
        .ctrl      (in_ctrl),
        .held_body (skid_body),
        .held_ctrl (skid_ctrl)
    );
`else
    assign in_ready    = reset & ~flush & (~out_valid | out_ready);
    assign main_body_d = in_body;
    assign main_ctrl_d = in_ctrl;
`endif

    idex_slot #(.BODY_W(BODY_W), .CTRL_W(CTRL_W)) u_main (
        .clk       (clk),
        .reset     (reset),
        .load      (main_load),
        .clear     (main_clear),
        .body      (main_body_d),
        .ctrl      (main_ctrl_d),
        .held_body (main_body),
        .held_ctrl (out_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case infers a latch.
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
`ifdef IDEX_SKID_EN
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
`endif
        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
`ifdef IDEX_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
`ifdef IDEX_SKID_EN
                        state_d   = TWO;
                        skid_load = 1'b1;
`endif
                    end else if (accept) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                TWO: begin
`ifdef IDEX_SKID_EN
                    if (pop) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
`else
                    state_d = EMPTY;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed and random bench for idex_pipe_reg with a FIFO scoreboard model.
// Expected in_ready follows the build selected by IDEX_SKID_EN.
module tb_idex_pipe_reg;

    localparam int DATA_W  = 8;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int CTRL_W  = 11;
`ifdef IDEX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  rd1;
        logic [7:0]  rd2;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [10:0] ctrl;
    } beat_t;

    logic               clk;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_rd1, in_rd2;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc4;
    logic [CTRL_W-1:0]  in_ctrl;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_rd1, out_rd2;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc4;
    logic [CTRL_W-1:0]  out_ctrl;

    idex_pipe_reg #(
        .DATA_W(DATA_W), .INSTR_W(INSTR_W), .PC_W(PC_W), .CTRL_W(CTRL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd1    (in_rd1),
        .in_rd2    (in_rd2),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd1   (out_rd1),
        .out_rd2   (out_rd2),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .out_ctrl  (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    pops     = 0;
    beat_t sb[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic beat_t cur_beat();
        beat_t b;
        b = {out_rd1, out_rd2, out_instr, out_pc4, out_ctrl};
        return b;
    endfunction

    function automatic beat_t mk(input int i);
        beat_t b;
        b.rd1   = 8'(i);
        b.rd2   = ~8'(i);
        b.instr = 32'h1000_0000 + 32'(i);
        b.pc4   = 32'(4 * i + 4);
        b.ctrl  = 11'(i * 37 + 5);
        return b;
    endfunction

    task automatic present(input beat_t b);
        in_valid = 1'b1;
        {in_rd1, in_rd2, in_instr, in_pc4, in_ctrl} = b;
    endtask

    // One cycle: compare against the model, advance the model, move to next negedge.
    task automatic tick(output bit acc);
        bit    exp_rdy, exp_val, pp;
        beat_t b, dropped;
        #1;
        exp_val = (sb.size() != 0);
        if (SKID) exp_rdy = reset && !flush && (sb.size() < 2);
        else      exp_rdy = reset && !flush && (!exp_val || out_ready);
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        check("out_valid", 128'(out_valid), 128'(exp_val));
        if (exp_val) check("payload", 128'(cur_beat()), 128'(sb[0]));
        else         check("bubble_ctrl", 128'(out_ctrl), 128'(0));
        acc = in_valid && exp_rdy;
        pp  = exp_val && out_ready;
        b   = {in_rd1, in_rd2, in_instr, in_pc4, in_ctrl};
        if (!reset || flush) begin
            sb.delete();
            acc = 1'b0;
        end else begin
            if (pp) begin
                dropped = sb.pop_front();
                pops++;
            end
            if (acc) sb.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit    acc;
        int    idx;
        beat_t first;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        {in_rd1, in_rd2, in_instr, in_pc4, in_ctrl} = '0;

        // Reset held for two edges
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(0));
        check("rst_rd1",   128'(out_rd1),   128'(0));
        check("rst_rd2",   128'(out_rd2),   128'(0));
        check("rst_instr", 128'(out_instr), 128'(0));
        check("rst_pc4",   128'(out_pc4),   128'(0));
        check("rst_ctrl",  128'(out_ctrl),  128'(0));

        reset = 1'b1;
        tick(acc);

        // Single beat, one-cycle latency
        first = {8'hA5, 8'h3C, 32'h0123_4567, 32'h0000_0004, 11'h7FF};
        present(first);
        tick(acc);
        in_valid = 1'b0;
        #1;
        check("first_valid", 128'(out_valid), 128'(1));
        check("first_payload", 128'(cur_beat()), 128'(first));
        tick(acc);
        out_ready = 1'b1;
        tick(acc);
        #1;
        check("idle_valid", 128'(out_valid), 128'(0));
        check("idle_bubble", 128'(out_ctrl), 128'(0));
        tick(acc);

        // Streaming 16 beats, no gaps
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            present(mk(i));
            tick(acc);
        end
        in_valid = 1'b0;
        tick(acc);
        check("stream_pops", 128'(pops), 128'(16));

        // Back-pressure for 3 cycles mid-stream
        idx = 16;
        for (int i = 0; i < 3; i++) begin
            present(mk(idx));
            tick(acc);
            if (acc) idx++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            present(mk(idx));
            #1;
            if (c == 0) check("bp_ready_first", 128'(in_ready), 128'(SKID));
            else        check("bp_ready_stall", 128'(in_ready), 128'(0));
            tick(acc);
            if (acc) idx++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(mk(idx));
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(acc);

        // Fill completely, then flush with a beat on the input
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(mk(idx));
            tick(acc);
            if (acc) idx++;
        end
        flush = 1'b1;
        present(mk(idx + 1));
        #1;
        check("flush_in_ready", 128'(in_ready), 128'(0));
        tick(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("flush_valid", 128'(out_valid), 128'(0));
        check("flush_ctrl",  128'(out_ctrl),  128'(0));
        for (int i = 0; i < 3; i++) tick(acc);
        idx += 2;

        // Reset while stalled full
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            present(mk(idx));
            tick(acc);
            if (acc) idx++;
        end
        reset = 1'b0;
        present(mk(idx));
        tick(acc);
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_ready", 128'(in_ready),  128'(0));
        check("mid_rst_body",  128'({out_rd1, out_rd2, out_instr, out_pc4}), 128'(0));
        check("mid_rst_ctrl",  128'(out_ctrl),  128'(0));
        reset = 1'b1;
        present(mk(idx + 50));
        tick(acc);
        in_valid = 1'b0;
        #1;
        check("post_rst_valid", 128'(out_valid), 128'(1));
        check("post_rst_rd1",   128'(out_rd1),   128'(8'(idx + 50)));
        out_ready = 1'b1;
        tick(acc);
        idx += 51;

        // Random traffic with occasional flush
        for (int c = 0; c < 300; c++) begin
            present(mk(idx));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            tick(acc);
            if (acc) idx++;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick(acc);
        #1;
        check("drain_valid", 128'(out_valid), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/idex_pipe_reg.md
# idex_pipe_reg

Parametrised ID/EX pipeline register with a valid/ready handshake, synchronous flush and bubble insertion. It sits between the decode and execute stages and carries the operands, the instruction word, PC+4 and the control bundle. Unlike a plain enable-less register, it can stall upstream, drop wrong-path work on a branch or jump flush, and optionally decouple `in_ready` timing through a skid slot.

## Interface
- `DATA_W`, 8: register-file operand width.
- `INSTR_W`, 32: instruction word width.
- `PC_W`, 32: PC+4 width.
- `CTRL_W`, 11: packed control bundle width, in this order: ALUOp[1:0], ALUSrc, RegDst, Branch, BranchFlip, MemRead, MemWrite, Jump, RegWrite, MemtoReg.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `flush`  in  1  discard all held and incoming beats this cycle.
- `in_valid`  in  1  decode presents a beat.
- `in_ready`  out  1  stage can accept a beat.
- `in_rd1`, `in_rd2`  in  DATA_W  operands.
- `in_instr`  in  INSTR_W  instruction word.
- `in_pc4`  in  PC_W  PC+4.
- `in_ctrl`  in  CTRL_W  control bundle.
- `out_valid`  out  1  execute-side beat valid.
- `out_ready`  in  1  execute consumes the beat.
- `out_rd1`, `out_rd2`, `out_instr`, `out_pc4`, `out_ctrl`  out  widths as inputs  registered payload.

## Operation
- Accept happens when `in_valid & in_ready`. Pop happens when `out_valid & out_ready`.
- Payload is captured whole. No field is ever mixed between beats.
- Bubble rule: when `out_valid` is 0, `out_ctrl` is all zero. Downstream logic that ignores valid therefore never writes a register or memory.
- Flush has priority over everything else:
  - `out_valid` drops to 0 and any skid entry is discarded.
  - `out_ctrl` is zeroed.
  - A beat accepted in the same cycle is dropped.
  - `in_ready` is 0 while `flush` is high.
- Reset (`reset` low at a clock edge):
  - All outputs become 0, including every payload field.
  - The skid slot is emptied.
  - `in_ready` is 0 while `reset` is low and returns to 1 on the first cycle after release.
- Without skid, the state machine is EMPTY / FULL:
  - EMPTY + accept → FULL.
  - FULL + pop and no accept → EMPTY.
  - FULL + pop + accept → FULL, holding the new beat.
  - `in_ready = ~out_valid | out_ready`.
- With skid, the state machine is EMPTY / ONE / TWO:
  - EMPTY + accept → ONE.
  - ONE + accept + pop → ONE, with main taking the new beat.
  - ONE + accept, no pop → TWO, with the beat going to the skid slot.
  - ONE + pop, no accept → EMPTY.
  - TWO + pop → ONE, with main loaded from skid. No accept is possible in TWO.
- Ordering is strictly FIFO. No beat is duplicated or lost except on flush or reset.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- Throughput is 1 beat per cycle while `out_ready` is held high.
- Without skid, `in_ready` is combinational from `out_ready` and `flush`.
- With skid, `in_ready` is registered (it is 0 only in TWO), with `flush` and `reset` gating it combinationally.
- Payload outputs change only on a clock edge.
- Holding `out_ready` low keeps all outputs stable indefinitely.

## Configuration
- `IDEX_SKID_EN` defined: 2-entry (main plus skid) operation. `in_ready` does not depend combinationally on `out_ready`.
- `IDEX_SKID_EN` undefined: single register. `in_ready` passes `out_ready` through combinationally, which costs less area.
- Observable beat ordering and latency are identical in both builds. Only the stall-cycle `in_ready` behaviour differs.

## Structure
- Shared package `idex_pkg` holds:
  - `idex_ctrl_t`, the packed control struct in the field order above.
  - `IDEX_BUBBLE`, the all-zero control constant.
  - The state enum `idex_state_t` (EMPTY/ONE/TWO).
- Natural sub-module: `idex_slot`, one payload register with load, clear and bubble-zeroing. It is instantiated once for main and once more for skid when `IDEX_SKID_EN` is defined.

## Test plan
- **Reset then single beat.** Hold reset low for 2 cycles; all outputs must be 0 and `in_ready` 0. Release reset, then send rd1=8'hA5, rd2=8'h3C, instr=32'h0123_4567, pc4=32'h0000_0004, ctrl=11'h7FF. Expect `out_valid`=1 one cycle later with exact payload.
- **Streaming.** Send 16 beats (rd1 = 0..15) with `out_ready`=1. Expect output in order, 1 per cycle, with no gaps after the first.
- **Back-pressure.** Drop `out_ready` for 3 cycles mid-stream.
  - Skid build: accepts one extra beat, then `in_ready`=0.
  - Non-skid build: `in_ready`=0 immediately.
  - In both builds, no beat is lost and order is kept.
- **Flush in full state.** Fill to TWO (skid) or FULL, then assert `flush` together with `in_valid`. Next cycle: `out_valid`=0, `out_ctrl`=0, and the flushed beats never appear.
- **Reset mid-stall.** Assert reset while full with `out_ready`=0. Next cycle all outputs are 0. The first beat after release appears with 1-cycle latency.
- **Bubble check.** Idle with `in_valid`=0 after a beat carrying ctrl=11'h7FF pops. `out_ctrl` must read 0 while `out_valid`=0.
